// File: rtl/painterengine_gpu_reader_pkg.sv
// Shared AXI constants and reader FSM state encoding for the painterengine GPU read path.
package painterengine_gpu_reader_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCalc  = 3'd1,
    StAddr  = 3'd2,
    StData  = 3'd3,
    StDone  = 3'd4,
    StError = 3'd5
  } reader_state_e;

endpackage

// File: rtl/painterengine_gpu_reader_burstcalc.sv
// Registered burst sizing: min(remaining words, max burst, words left in the current 4 KB page).
module painterengine_gpu_reader_burstcalc #(
  parameter int unsigned PARAM_MAX_BURST = 16,
  parameter int unsigned PARAM_LEN_WIDTH = 32,
  parameter int unsigned BEAT_WIDTH      = $clog2(PARAM_MAX_BURST) + 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic [PARAM_LEN_WIDTH-1:0] remaining,
  input  logic [9:0]                 word_offset,
  output logic [BEAT_WIDTH-1:0]      beats,
  output logic [7:0]                 arlen
);

  logic [10:0] gap_words;
  logic [10:0] limit;
  logic [10:0] pick;
  logic [BEAT_WIDTH-1:0] beats_q;
  logic [7:0]            arlen_q;

  // Word offset within the page is addr[11:2]; gap is 1..1024 words.
  always_comb begin
    gap_words = 11'h400 - {1'b0, word_offset};
    limit     = (gap_words < 11'(PARAM_MAX_BURST)) ? gap_words : 11'(PARAM_MAX_BURST);
    pick      = (remaining < PARAM_LEN_WIDTH'(limit)) ? 11'(remaining) : limit;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      beats_q <= '0;
      arlen_q <= '0;
    end else if (enable) begin
      beats_q <= BEAT_WIDTH'(pick);
      arlen_q <= 8'(pick - 11'd1);
    end
  end

  assign beats = beats_q;
  assign arlen = arlen_q;

endmodule

// File: rtl/painterengine_gpu_reader.sv
// AXI4 read-master DMA: fetches a linear run of 32-bit words in INCR bursts and streams
// them straight to the display consumer, honouring its data_next backpressure.
module painterengine_gpu_reader
  import painterengine_gpu_reader_pkg::*;
#(
  parameter int unsigned PARAM_MAX_BURST = 16,
  parameter int unsigned PARAM_LEN_WIDTH = 32
) (
  input  logic                       i_wire_clock,
  input  logic                       i_wire_resetn,
  input  logic [31:0]                i_wire_address,
  input  logic [PARAM_LEN_WIDTH-1:0] i_wire_length,
  output logic                       o_wire_done,
  output logic                       o_wire_error,
  output logic [31:0]                o_wire_data,
  output logic                       o_wire_data_valid,
  input  logic                       i_wire_data_next,
  output logic [31:0]                o_wire_m_axi_araddr,
  output logic [7:0]                 o_wire_m_axi_arlen,
  output logic [2:0]                 o_wire_m_axi_arsize,
  output logic [1:0]                 o_wire_m_axi_arburst,
  output logic                       o_wire_m_axi_arvalid,
  input  logic                       i_wire_m_axi_arready,
  input  logic [31:0]                i_wire_m_axi_rdata,
  input  logic [1:0]                 i_wire_m_axi_rresp,
  input  logic                       i_wire_m_axi_rlast,
  input  logic                       i_wire_m_axi_rvalid,
  output logic                       o_wire_m_axi_rready
);

  localparam int unsigned BeatWidth = $clog2(PARAM_MAX_BURST) + 1;

  reader_state_e              state_q, state_d;
  logic [31:0]                addr_q, addr_d;
  logic [PARAM_LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [BeatWidth-1:0]       beat_cnt_q, beat_cnt_d;
  logic                       err_q, err_d;
  logic [BeatWidth-1:0]       beats;
  logic [7:0]                 arlen;
  logic                       last_cnt;
  logic                       err_next;

  painterengine_gpu_reader_burstcalc #(
    .PARAM_MAX_BURST (PARAM_MAX_BURST),
    .PARAM_LEN_WIDTH (PARAM_LEN_WIDTH),
    .BEAT_WIDTH      (BeatWidth)
  ) u_burstcalc (
    .clock       (i_wire_clock),
    .resetn      (i_wire_resetn),
    .enable      (state_q == StCalc),
    .remaining   (remaining_q),
    .word_offset (addr_q[11:2]),
    .beats       (beats),
    .arlen       (arlen)
  );

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    remaining_d          = remaining_q;
    beat_cnt_d           = beat_cnt_q;
    err_d                = err_q;
    last_cnt             = 1'b0;
    err_next             = err_q;
    o_wire_m_axi_arvalid = 1'b0;
    o_wire_m_axi_rready  = 1'b0;
    o_wire_data_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_d      = i_wire_address;
        remaining_d = i_wire_length;
        beat_cnt_d  = '0;
        err_d       = 1'b0;
        if (i_wire_length == '0)             state_d = StDone;
        else if (i_wire_address[1:0] != 2'b00) state_d = StError;
        else                                   state_d = StCalc;
      end
      StCalc: state_d = StAddr;
      StAddr: begin
        o_wire_m_axi_arvalid = 1'b1;
        beat_cnt_d           = '0;
        if (i_wire_m_axi_arready) state_d = StData;
      end
      StData: begin
        o_wire_m_axi_rready = i_wire_data_next;
        o_wire_data_valid   = i_wire_m_axi_rvalid;
        if (i_wire_m_axi_rvalid && i_wire_data_next) begin
          last_cnt   = (beat_cnt_q == beats - BeatWidth'(1));
          err_next   = err_q || (i_wire_m_axi_rresp != AXI_RESP_OKAY) ||
                       (i_wire_m_axi_rlast != last_cnt);
          err_d      = err_next;
          beat_cnt_d = beat_cnt_q + BeatWidth'(1);
          // An early RLAST also closes the burst so a short slave cannot stall the reader.
          if (last_cnt || i_wire_m_axi_rlast) begin
            if (err_next) begin
              state_d = StError;
            end else if (remaining_q == PARAM_LEN_WIDTH'(beats)) begin
              state_d = StDone;
            end else begin
              addr_d      = addr_q + (32'(beats) << 2);
              remaining_d = remaining_q - PARAM_LEN_WIDTH'(beats);
              state_d     = StCalc;
            end
          end
        end
      end
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign o_wire_done          = (state_q == StDone);
  assign o_wire_error         = (state_q == StError);
  assign o_wire_data          = i_wire_m_axi_rdata;
  assign o_wire_m_axi_araddr  = addr_q;
  assign o_wire_m_axi_arlen   = arlen;
  assign o_wire_m_axi_arsize  = AXI_SIZE_4B;
  assign o_wire_m_axi_arburst = AXI_BURST_INCR;

endmodule
